pad_ctrl: RTL and testbench

Core-side companion to the pad ring. It resynchronises every pad-to-core input (input_in, bidir_in) into the clk domain. It holds the per-pad electrical configuration (CS/SL/IE/PU/PD/OE mode) in shadow/active register banks that firmware or a scan loader writes over a valid/ready port. It drives registered, glitch-free control and data outputs back to the pad cells. It sits at the top of chip_core, between the pad ring and the FPGA fabric.

---
 rtl/pad_ctrl_pkg.sv | 45 ++++
 rtl/pad_sync.sv | 64 ++++++
 rtl/pad_ctrl.sv | 159 +++++++++++++++
 tb/tb_pad_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared types for the pad controller: per-pad config word, output-enable modes,
// reset configuration and the config-port FSM states.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    OE_OFF   = 2'b00,
    OE_FORCE = 2'b01,
    OE_CORE  = 2'b10
  } oe_mode_e;

  // Field order matches the config word: [6:5] oe_mode, [4] sl, [3] cs, [2] pd, [1] pu, [0] ie
  typedef struct packed {
    oe_mode_e oe_mode;
    logic     sl;
    logic     cs;
    logic     pd;
    logic     pu;
    logic     ie;
  } pad_cfg_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } cfg_state_e;

  localparam pad_cfg_t CFG_RESET = '{oe_mode: OE_OFF, sl: 1'b0, cs: 1'b0,
                                     pd: 1'b0, pu: 1'b0, ie: 1'b1};

  // Pull-up wins a pu/pd conflict; both upper oe encodings mean "follow the fabric".
  function automatic pad_cfg_t cfg_sanitize(input logic [6:0] w);
    pad_cfg_t c;
    c.ie = w[0];
    c.pu = w[1];
    c.pd = w[2] & ~w[1];
    c.cs = w[3];
    c.sl = w[4];
    unique case (w[6:5])
      2'b00:   c.oe_mode = OE_OFF;
      2'b01:   c.oe_mode = OE_FORCE;
      default: c.oe_mode = OE_CORE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// One pad-to-core bit: 2-flop synchroniser, followed by a stable-count filter
// when PAD_CTRL_DEBOUNCE_EN is defined.
module pad_sync #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic core_o
);
  import pad_ctrl_pkg::*;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("pad_sync: DEBOUNCE_CYCLES must be >= 2");
  end

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
    end
  end

`ifdef PAD_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Counter only runs while the synced value disagrees with the output; any agreement clears it.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign core_o = filt_q;
`else
  assign core_o = sync_q;
`endif

endmodule

// File: rtl/pad_ctrl.sv
// Pad-ring companion: input resynchronisation, shadow/active pad config banks behind
// a valid/ready write port, and registered pad data/OE. Optional filter: PAD_CTRL_DEBOUNCE_EN.
module pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter  int NUM_INPUT_PADS  = 12,
  parameter  int NUM_BIDIR_PADS  = 40,
  parameter  int DEBOUNCE_CYCLES = 8,
  localparam int ADDR_W          = $clog2(NUM_INPUT_PADS + NUM_BIDIR_PADS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] core_input,
  output logic [NUM_BIDIR_PADS-1:0] core_bidir_in,
  input  logic [NUM_BIDIR_PADS-1:0] core_bidir_out,
  input  logic [NUM_BIDIR_PADS-1:0] core_bidir_oe,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [6:0]                cfg_wdata,
  input  logic                      cfg_commit,
  output logic                      cfg_err
);

  localparam int NUM_PADS = NUM_INPUT_PADS + NUM_BIDIR_PADS;

  cfg_state_e state_q, state_d;
  logic       run_q;
  logic       cfg_err_q;
  logic       wr_fire;
  logic       addr_oor;
  logic       commit_en;
  pad_cfg_t   cfg_word;

  // run_q keeps cfg_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cfg_err_q <= wr_fire & addr_oor;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_ready = run_q;
        if (run_q && cfg_commit) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign wr_fire   = cfg_valid & cfg_ready;
  assign addr_oor  = (32'(cfg_addr) >= NUM_PADS);
  assign commit_en = (state_q == S_COMMIT);
  assign cfg_word  = cfg_sanitize(cfg_wdata);
  assign cfg_err   = cfg_err_q;

  for (genvar gi = 0; gi < NUM_BIDIR_PADS; gi++) begin : g_bidir
    pad_cfg_t shadow_q;
    pad_cfg_t active_q;
    logic     out_q;
    logic     oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= CFG_RESET;
        active_q <= CFG_RESET;
      end else begin
        if (wr_fire && cfg_addr == ADDR_W'(gi)) shadow_q <= cfg_word;
        if (commit_en) active_q <= shadow_q;
      end
    end

    // Fabric data/OE only ever reach the pad through these flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= 1'b0;
        oe_q  <= 1'b0;
      end else begin
        unique case (active_q.oe_mode)
          OE_FORCE: begin
            out_q <= core_bidir_out[gi];
            oe_q  <= 1'b1;
          end
          OE_CORE: begin
            out_q <= core_bidir_out[gi];
            oe_q  <= core_bidir_oe[gi];
          end
          default: begin
            out_q <= 1'b0;
            oe_q  <= 1'b0;
          end
        endcase
      end
    end

    assign bidir_out[gi] = out_q;
    assign bidir_oe[gi]  = oe_q;
    assign bidir_cs[gi]  = active_q.cs;
    assign bidir_sl[gi]  = active_q.sl;
    assign bidir_ie[gi]  = active_q.ie;
    assign bidir_pu[gi]  = active_q.pu;
    assign bidir_pd[gi]  = active_q.pd;

    pad_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_i  (bidir_in[gi]),
      .core_o (core_bidir_in[gi])
    );
  end

  // Input pads only carry pull controls, so their bank entries hold just {pd, pu}.
  for (genvar gi = 0; gi < NUM_INPUT_PADS; gi++) begin : g_input
    logic [1:0] shadow_q;
    logic [1:0] active_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= {CFG_RESET.pd, CFG_RESET.pu};
        active_q <= {CFG_RESET.pd, CFG_RESET.pu};
      end else begin
        if (wr_fire && cfg_addr == ADDR_W'(NUM_BIDIR_PADS + gi)) shadow_q <= {cfg_word.pd, cfg_word.pu};
        if (commit_en) active_q <= shadow_q;
      end
    end

    assign input_pu[gi] = active_q[0];
    assign input_pd[gi] = active_q[1];

    pad_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_i  (input_in[gi]),
      .core_o (core_input[gi])
    );
  end

endmodule

// File: tb/tb_pad_ctrl.sv
// Directed bench for pad_ctrl: config banks, commit timing, error pulse, sync latency, reset mid-commit.
module tb_pad_ctrl;

  localparam int NI  = 12;
  localparam int NB  = 40;
  localparam int AW  = 6;
`ifdef PAD_CTRL_DEBOUNCE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] input_in;
  logic [NI-1:0] input_pu, input_pd;
  logic [NB-1:0] bidir_in;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] core_input;
  logic [NB-1:0] core_bidir_in;
  logic [NB-1:0] core_bidir_out, core_bidir_oe;
  logic          cfg_valid, cfg_ready, cfg_commit, cfg_err;
  logic [AW-1:0] cfg_addr;
  logic [6:0]    cfg_wdata;

  logic [NB-1:0] all_b;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pad_ctrl #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_in(input_in), .input_pu(input_pu), .input_pd(input_pd),
    .bidir_in(bidir_in), .bidir_out(bidir_out), .bidir_oe(bidir_oe),
    .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_ie(bidir_ie),
    .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .core_input(core_input), .core_bidir_in(core_bidir_in),
    .core_bidir_out(core_bidir_out), .core_bidir_oe(core_bidir_oe),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_err(cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_write(input logic [AW-1:0] addr, input logic [6:0] data, input logic commit);
    cfg_valid  = 1'b1;
    cfg_addr   = addr;
    cfg_wdata  = data;
    cfg_commit = commit;
    $display("cfg write addr=%0d data=%b commit=%0b t=%0t", addr, data, commit, $time);
  endtask

  initial begin
    all_b          = '1;
    rst_n          = 1'b0;
    input_in       = '0;
    bidir_in       = '0;
    core_bidir_out = '0;
    core_bidir_oe  = '0;
    cfg_valid      = 1'b0;
    cfg_addr       = '0;
    cfg_wdata      = '0;
    cfg_commit     = 1'b0;

    // 1. reset values
    #12;
    check("rst_bidir_ie", 64'(bidir_ie), 64'(all_b));
    check("rst_bidir_oe", 64'(bidir_oe), 64'h0);
    check("rst_pu_pd_cs_sl", 64'(bidir_pu | bidir_pd | bidir_cs | bidir_sl), 64'h0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'h0);
    check("rst_cfg_err", 64'(cfg_err), 64'h0);
    check("rst_core_input", 64'(core_input), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 64'(cfg_ready), 64'h1);

    // 2. write without commit, then commit
    drive_write(AW'(3), 7'b1000011, 1'b0);
    tick();
    cfg_valid = 1'b0;
    check("shadow_only_pu3", 64'(bidir_pu[3]), 64'h0);
    tick();
    check("shadow_only_pu3_hold", 64'(bidir_pu[3]), 64'h0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("commit_ready_low", 64'(cfg_ready), 64'h0);
    check("commit_pu3_not_yet", 64'(bidir_pu[3]), 64'h0);
    tick();
    check("commit_pu3", 64'(bidir_pu[3]), 64'h1);
    check("commit_ready_back", 64'(cfg_ready), 64'h1);
    check("commit_ie3", 64'(bidir_ie[3]), 64'h1);
    core_bidir_oe  = '1;
    core_bidir_out = '1;
    #1;
    check("no_comb_oe3", 64'(bidir_oe[3]), 64'h0);
    tick();
    check("core_oe3", 64'(bidir_oe[3]), 64'h1);
    check("core_out3", 64'(bidir_out[3]), 64'h1);
    check("off_oe4", 64'(bidir_oe[4]), 64'h0);
    check("off_out4", 64'(bidir_out[4]), 64'h0);

    // 3. input pad pu+pd conflict; commit held in COMMIT; write pending across COMMIT
    drive_write(AW'(NB + 2), 7'b0000110, 1'b0);
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b1;
    tick();
    drive_write(AW'(5), 7'b0000010, 1'b1);
    check("commit2_ready_low", 64'(cfg_ready), 64'h0);
    tick();
    cfg_commit = 1'b0;
    check("input_pu2", 64'(input_pu[2]), 64'h1);
    check("input_pd2_conflict", 64'(input_pd[2]), 64'h0);
    check("pending_ready", 64'(cfg_ready), 64'h1);
    tick();
    cfg_valid = 1'b0;
    check("commit_in_commit_ignored", 64'(cfg_ready), 64'h1);
    check("pending_pu5_shadow", 64'(bidir_pu[5]), 64'h0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    check("pending_pu5_active", 64'(bidir_pu[5]), 64'h1);

    // 4. out-of-range write, then write+commit in one cycle
    core_bidir_oe = '0;
    drive_write(AW'(NI + NB), 7'b1111111, 1'b0);
    #1;
    check("err_before", 64'(cfg_err), 64'h0);
    tick();
    cfg_valid = 1'b0;
    check("err_pulse", 64'(cfg_err), 64'h1);
    tick();
    check("err_clear", 64'(cfg_err), 64'h0);
    drive_write(AW'(0), 7'b0100001, 1'b1);
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    check("wc_ready_low", 64'(cfg_ready), 64'h0);
    tick();
    check("wc_oe0_latency", 64'(bidir_oe[0]), 64'h0);
    tick();
    check("force_oe", 64'(bidir_oe), 64'h1);
    check("force_out0", 64'(bidir_out[0]), 64'h1);
    check("oor_no_cs", 64'(bidir_cs | bidir_sl), 64'h0);
    check("oor_input_pu", 64'(input_pu), 64'h004);
    check("oor_input_pd", 64'(input_pd), 64'h000);

    // 5. synchroniser latency
    input_in[5] = 1'b1;
    repeat (LAT - 1) tick();
    check("sync_in5_early", 64'(core_input[5]), 64'h0);
    tick();
    check("sync_in5", 64'(core_input[5]), 64'h1);
    bidir_in[7] = 1'b1;
    repeat (LAT - 1) tick();
    check("sync_b7_early", 64'(core_bidir_in[7]), 64'h0);
    tick();
    check("sync_b7", 64'(core_bidir_in), 64'h80);
    bidir_in[7] = 1'b0;
    repeat (LAT - 1) tick();
    check("sync_b7_fall_early", 64'(core_bidir_in[7]), 64'h1);
    tick();
    check("sync_b7_fall", 64'(core_bidir_in[7]), 64'h0);
`ifdef PAD_CTRL_DEBOUNCE_EN
    input_in[6] = 1'b1;
    repeat (5) tick();
    input_in[6] = 1'b0;
    repeat (15) tick();
    check("glitch_suppressed", 64'(core_input[6]), 64'h0);
`endif

    // 6. reset asserted during COMMIT
    drive_write(AW'(10), 7'b0011000, 1'b0);
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ie", 64'(bidir_ie), 64'(all_b));
    check("mid_rst_pu_cs", 64'(bidir_pu | bidir_cs | bidir_sl | bidir_pd), 64'h0);
    check("mid_rst_oe", 64'(bidir_oe | bidir_out), 64'h0);
    check("mid_rst_input_pu", 64'(input_pu), 64'h0);
    check("mid_rst_core_input", 64'(core_input), 64'h0);
    check("mid_rst_ready", 64'(cfg_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(cfg_ready), 64'h1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    check("post_rst_ie", 64'(bidir_ie), 64'(all_b));
    check("post_rst_bank", 64'(bidir_pu | bidir_cs | bidir_sl | bidir_pd), 64'h0);
    check("post_rst_input_pu", 64'(input_pu), 64'h0);
    check("post_rst_oe", 64'(bidir_oe), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
